// File: rtl/seq_detector_p.sv
// seq_detector_p: serial sequence detector with a run-time pattern and overlap mode.
// Optional match counter is built when SEQDET_COUNT_EN is defined.
module seq_detector_p #(
    parameter int               PAT_W   = 8,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(8'b0000_1011),
    parameter int               RST_LEN = 4,
    parameter bit               RST_OVL = 1'b1,
    localparam int              SW      = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [SW-1:0]    cfg_len,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             seqcheck,
    output logic [SW-1:0]    state,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [SW-1:0] PAT_W_C = SW'(PAT_W);
    localparam logic [SW-1:0] RST_LEN_C =
        (RST_LEN < 1)     ? SW'(1)     :
        (RST_LEN > PAT_W) ? SW'(PAT_W) :
                            SW'(RST_LEN);

    // Active configuration
    logic [PAT_W-1:0] pat;
    logic [SW-1:0]    len;
    logic             ovl;

    // Only PAT_W-1 old bits are kept: with the incoming bit they
    // form the full PAT_W window, so an older bit can never match.
    logic [PAT_W-2:0] hist;
    logic [SW-1:0]    fill;

    logic [PAT_W-1:0] h_new;
    logic [SW:0]      fill_p1;
    logic [SW-1:0]    best;
    logic [SW-1:0]    fill_nxt;
    logic [SW-1:0]    len_c;
    logic             hit;
    logic             match_acc;

    // Clamp the requested length into 1..PAT_W
    always_comb begin
        len_c = cfg_len;
        if (cfg_len == '0) begin
            len_c = SW'(1);
        end else if (cfg_len > PAT_W_C) begin
            len_c = PAT_W_C;
        end
    end

    // Longest pattern prefix that ends on the newest bit
    always_comb begin
        h_new   = {hist, din};
        fill_p1 = {1'b0, fill} + (SW+1)'(1);
        best    = '0;
        for (int k = 1; k <= PAT_W; k++) begin
            if ((SW'(k) <= len) &&
                ((SW+1)'(k) <= fill_p1) &&
                (((h_new ^ (pat >> (len - SW'(k)))) &
                  ~({PAT_W{1'b1}} << k)) == '0)) begin
                best = SW'(k);
            end
        end
    end

    assign hit       = (best == len);
    assign match_acc = din_valid & ~cfg_load & hit;
    assign fill_nxt  = (fill == PAT_W_C) ? fill : fill + SW'(1);

    // Configuration, history and match progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat      <= RST_PAT;
            len      <= RST_LEN_C;
            ovl      <= RST_OVL;
            hist     <= '0;
            fill     <= '0;
            state    <= '0;
            seqcheck <= 1'b0;
        end else if (cfg_load) begin
            pat      <= cfg_pattern;
            len      <= len_c;
            ovl      <= cfg_overlap;
            hist     <= '0;
            fill     <= '0;
            state    <= '0;
            seqcheck <= 1'b0;
        end else if (din_valid) begin
            state    <= best;
            seqcheck <= hit;
            if (hit && !ovl) begin
                hist <= '0;
                fill <= '0;
            end else begin
                hist <= h_new[PAT_W-2:0];
                fill <= fill_nxt;
            end
        end else begin
            seqcheck <= 1'b0;
        end
    end

`ifdef SEQDET_COUNT_EN
    // Saturating match counter; a clear wins over a same-edge match
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= '0;
        end else if (match_acc && (match_cnt != '1)) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end
`else
    logic cnt_unused;

    assign match_cnt  = '0;
    assign cnt_unused = cnt_clr ^ match_acc;
`endif

endmodule

// File: tb/tb_seq_detector_p.sv
// tb_seq_detector_p: scoreboard bench for seq_detector_p.
// Two instances share stimulus; the second has a 2-bit counter.
module tb_seq_detector_p;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic       cnt_clr = 1'b0;

    logic       seqcheck, seqcheck_s;
    logic [3:0] state, state_s;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt_s;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int st;
        bit sq;
        int c;
        int c2;
    } exp_t;

    exp_t exp_q[$];

    logic [7:0] m_pat = 8'b0000_1011;
    int         m_len = 4;
    bit         m_ovl = 1'b1;
    bit         m_q[$];
    int         m_st = 0;
    int         m_cnt = 0;
    int         m_cnt2 = 0;

    always #5 clk = ~clk;

    seq_detector_p dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .seqcheck(seqcheck), .state(state),
        .match_cnt(match_cnt)
    );

    seq_detector_p #(.CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .seqcheck(seqcheck_s), .state(state_s),
        .match_cnt(match_cnt_s)
    );

    function automatic void model_reset();
        m_pat  = 8'b0000_1011;
        m_len  = 4;
        m_ovl  = 1'b1;
        m_q.delete();
        m_st   = 0;
        m_cnt  = 0;
        m_cnt2 = 0;
    endfunction

    // Reference: search the accepted-bit list for the longest pattern
    // prefix ending on the newest bit.
    function automatic void model_step(bit ld, logic [7:0] p, int l,
                                       bit o, bit v, bit d, bit clr);
        bit   hit = 1'b0;
        bit   sq = 1'b0;
        int   bst;
        bit   ok;
        exp_t e;
        if (ld) begin
            m_pat = p;
            m_len = (l == 0) ? 1 : ((l > 8) ? 8 : l);
            m_ovl = o;
            m_q.delete();
            m_st = 0;
        end else if (v) begin
            m_q.push_back(d);
            if (m_q.size() > 8) void'(m_q.pop_front());
            bst = 0;
            for (int k = 1; k <= m_len && k <= m_q.size(); k++) begin
                ok = 1'b1;
                for (int i = 0; i < k; i++) begin
                    if (m_q[m_q.size() - 1 - i] != m_pat[m_len - k + i])
                        ok = 1'b0;
                end
                if (ok) bst = k;
            end
            m_st = bst;
            hit  = (bst == m_len);
            sq   = hit;
            if (hit && !m_ovl) m_q.delete();
        end
        if (clr) begin
            m_cnt  = 0;
            m_cnt2 = 0;
        end else if (hit) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        e.st = m_st;
        e.sq = sq;
`ifdef SEQDET_COUNT_EN
        e.c  = m_cnt;
        e.c2 = m_cnt2;
`else
        e.c  = 0;
        e.c2 = 0;
`endif
        exp_q.push_back(e);
    endfunction

    task automatic drive(input bit ld, input logic [7:0] p, input int l,
                         input bit o, input bit v, input bit d,
                         input bit clr);
        @(negedge clk);
        cfg_load    = ld;
        cfg_pattern = p;
        cfg_len     = 4'(l);
        cfg_overlap = o;
        din_valid   = v;
        din         = d;
        cnt_clr     = clr;
        model_step(ld, p, l, o, v, d, clr);
    endtask

    task automatic bit_in(input bit d);
        drive(1'b0, 8'h00, 0, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [7:0] p, input int l, input bit o);
        drive(1'b1, p, l, o, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic bits(input logic [31:0] v, input int n);
        logic [31:0] t;
        t = v;
        for (int i = n - 1; i >= 0; i--) bit_in(t[i]);
    endtask

    task automatic check_zero(input string name);
        n_checks++;
        if (state !== 4'd0 || seqcheck !== 1'b0 || match_cnt !== 8'd0 ||
            state_s !== 4'd0 || seqcheck_s !== 1'b0 ||
            match_cnt_s !== 2'd0) begin
            n_fail++;
            $display("FAIL %s: state=%0d/%0d seq=%0b/%0b cnt=%0d/%0d required all 0",
                     name, state, state_s, seqcheck, seqcheck_s,
                     match_cnt, match_cnt_s);
        end
    endtask

    // Monitor: the DUT presents a fresh output after every edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (int'(state) != e.st || int'(state_s) != e.st ||
                    seqcheck !== e.sq || seqcheck_s !== e.sq ||
                    int'(match_cnt) != e.c || int'(match_cnt_s) != e.c2) begin
                    n_fail++;
                    $display("FAIL scoreboard @%0t: state=%0d/%0d seq=%0b/%0b cnt=%0d cnt2=%0d required state=%0d seq=%0b cnt=%0d cnt2=%0d",
                             $time, state, state_s, seqcheck, seqcheck_s,
                             match_cnt, match_cnt_s, e.st, e.sq, e.c, e.c2);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rp;
        int r;
        #12;
        check_zero("reset_hold");
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // Defaults, overlap on
        bits(32'b1011011, 7);

        // Non-overlapping 1011
        load(8'b1011, 4, 1'b0);
        bits(32'b1011011, 7);

        // 111 overlap, then non-overlap
        load(8'b111, 3, 1'b1);
        bits(32'b11111, 5);
        load(8'b111, 3, 1'b0);
        bits(32'b11111, 5);

        // Gaps between valid bits
        load(8'b1011, 4, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            rp = 8'b1011;
            bit_in(rp[i]);
            idle();
            idle();
        end

        // Load while progress is 3 and a bit is valid
        bits(32'b101, 3);
        drive(1'b1, 8'b1011, 4, 1'b1, 1'b1, 1'b1, 1'b0);
        bits(32'b1011, 4);

        // Clear on a match edge
        bits(32'b101, 3);
        drive(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Back-to-back matches saturate the 2-bit counter
        load(8'b11, 2, 1'b1);
        bits(32'b111111, 6);

        // Full-length pattern
        load(8'hA5, 8, 1'b0);
        bits(32'h3CA5, 16);
        bits(32'h00A5, 8);

        // Length 0 acts as length 1; over-length clamps
        load(8'b0000_0001, 0, 1'b1);
        bits(32'b1101_0011, 8);
        load(8'h5A, 12, 1'b1);
        bits(32'h5A5A, 16);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
                rp = 8'($urandom);
                drive(1'b1, rp, $urandom_range(0, 12),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'b0);
            end else begin
                drive(1'b0, 8'h00, 0, 1'b0,
                      ($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 1)),
                      ($urandom_range(0, 49) == 0));
            end
        end

        // Asynchronous reset mid-pattern, then default pattern again
        load(8'b1011, 4, 1'b1);
        bits(32'b101, 3);
        @(negedge clk);
        din_valid = 1'b0;
        cfg_load  = 1'b0;
        cnt_clr   = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_zero("reset_async");
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        bits(32'b1011011, 7);

        idle();
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending=%0d required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
